coeff_bank_ctrl: RTL and testbench

- Ping-pong coefficient bank controller for the coefficient-selection datapath.
- Owns the two coefficient banks (A/B) and the bank-select bit that the destination clock domain samples.
- Loads each new coefficient set into the inactive bank only, waits a settle window, flips select, then waits a second settle window before it accepts another update.
- The settle windows ensure select never changes while bank bits are in flight, and banks never change while select is in flight.

---
 rtl/coeff_bank_if.sv | 24 ++
 rtl/coeff_bank_ctrl.sv | 103 ++++++++++
 tb/tb_coeff_bank_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/coeff_bank_if.sv
// Update handshake and bank outputs of the ping-pong coefficient bank controller.
// Signal names keep the controller's original port names so existing wiring maps one-to-one.
interface coeff_bank_if #(
  parameter int NB = 8
);
  logic [NB-1:0] i_coeffs;
  logic          i_update_valid;
  logic          o_update_ready;
  logic [NB-1:0] o_coeffs_a;
  logic [NB-1:0] o_coeffs_b;
  logic          o_sel;
  logic          o_busy;
  logic          o_switch_done;

  modport master (
    output i_coeffs, i_update_valid,
    input  o_update_ready, o_coeffs_a, o_coeffs_b, o_sel, o_busy, o_switch_done
  );

  modport slave (
    input  i_coeffs, i_update_valid,
    output o_update_ready, o_coeffs_a, o_coeffs_b, o_sel, o_busy, o_switch_done
  );
endinterface

// File: rtl/coeff_bank_ctrl.sv
// Ping-pong coefficient bank controller: loads the inactive bank, waits a settle
// window, flips the bank select, then waits a second window before the next update.
module coeff_bank_ctrl #(
  parameter int NB            = 8,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  coeff_bank_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE_DATA = 2'd1,
    SETTLE_SEL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [NB-1:0] r_coeffs_a;
  logic [NB-1:0] r_coeffs_b;
  logic          r_sel;
  logic          r_switch_done;
  logic          w_ready;
  logic          w_load_a;
  logic          w_load_b;
  logic          w_toggle;
  logic          w_done_next;

  assign w_ready = (r_state == IDLE);

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_toggle     = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_update_valid) begin
          // Only the bank not currently selected may be written.
          w_load_a     = r_sel;
          w_load_b     = ~r_sel;
          w_next_state = SETTLE_DATA;
          w_cnt_next   = CNT_LOAD;
        end
      end
      SETTLE_DATA: begin
        if (r_cnt == '0) begin
          w_toggle     = 1'b1;
          w_next_state = SETTLE_SEL;
          w_cnt_next   = CNT_LOAD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      SETTLE_SEL: begin
        if (r_cnt == '0) begin
          w_done_next  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_coeffs_a    <= '0;
      r_coeffs_b    <= '0;
      r_sel         <= 1'b0;
      r_switch_done <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_next;
      r_sel         <= r_sel ^ w_toggle;
      r_switch_done <= w_done_next;
      if (w_load_a) r_coeffs_a <= bus.i_coeffs;
      if (w_load_b) r_coeffs_b <= bus.i_coeffs;
    end
  end

  assign bus.o_update_ready = w_ready;
  assign bus.o_busy         = ~w_ready;
  assign bus.o_coeffs_a     = r_coeffs_a;
  assign bus.o_coeffs_b     = r_coeffs_b;
  assign bus.o_sel          = r_sel;
  assign bus.o_switch_done  = r_switch_done;

endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// Bench for coeff_bank_ctrl: two instances (SETTLE_CYCLES 8 and 1) checked every cycle
// against an edge-count model, plus directed literal expectations.
module tb_coeff_bank_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8 = 1'b1;
  logic rst1 = 1'b1;
  coeff_bank_if #(.NB(8)) if8 ();
  coeff_bank_if #(.NB(8)) if1 ();

  coeff_bank_ctrl #(.NB(8), .SETTLE_CYCLES(8)) u8 (
    .i_clock(clk), .i_reset(rst8), .bus(if8.slave)
  );
  coeff_bank_ctrl #(.NB(8), .SETTLE_CYCLES(1)) u1 (
    .i_clock(clk), .i_reset(rst1), .bus(if1.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: banks/select plus the edge index of the pending accept (-1 when idle).
  int         ecyc = 0;
  logic [7:0] ma [2];
  logic [7:0] mb [2];
  logic       msel [2];
  logic       mdone [2];
  int         macc [2];

  task automatic model_step(input int k, input int s, input logic rst,
                            input logic v, input logic [7:0] d);
    if (rst) begin
      ma[k] = 8'h00; mb[k] = 8'h00; msel[k] = 1'b0; mdone[k] = 1'b0; macc[k] = -1;
    end else begin
      mdone[k] = 1'b0;
      if (macc[k] >= 0) begin
        if (ecyc - macc[k] == s) msel[k] = ~msel[k];
        if (ecyc - macc[k] == 2 * s) begin
          mdone[k] = 1'b1;
          macc[k]  = -1;
        end
      end else if (v) begin
        if (msel[k]) ma[k] = d; else mb[k] = d;
        macc[k] = ecyc;
      end
    end
  endtask

  always @(posedge clk) begin
    ecyc++;
    model_step(0, 8, rst8, if8.i_update_valid, if8.i_coeffs);
    model_step(1, 1, rst1, if1.i_update_valid, if1.i_coeffs);
  end

  task automatic cmp_dut(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic sel, input logic rdy, input logic busy, input logic done);
    chk($sformatf("m%0d_a", k), 32'(a), 32'(ma[k]));
    chk($sformatf("m%0d_b", k), 32'(b), 32'(mb[k]));
    chk($sformatf("m%0d_sel", k), 32'(sel), 32'(msel[k]));
    chk($sformatf("m%0d_ready", k), 32'(rdy), 32'(macc[k] < 0));
    chk($sformatf("m%0d_busy", k), 32'(busy), 32'(macc[k] >= 0));
    chk($sformatf("m%0d_done", k), 32'(done), 32'(mdone[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, if8.o_coeffs_a, if8.o_coeffs_b, if8.o_sel, if8.o_update_ready,
              if8.o_busy, if8.o_switch_done);
      cmp_dut(1, if1.o_coeffs_a, if1.o_coeffs_b, if1.o_sel, if1.o_update_ready,
              if1.o_busy, if1.o_switch_done);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    if8.i_update_valid = 1'b0; if8.i_coeffs = 8'h00;
    if1.i_update_valid = 1'b0; if1.i_coeffs = 8'h00;
    step(2);
    rst8 = 1'b0; rst1 = 1'b0;
    chk_en = 1'b1;
    chk("rst_a", 32'(if8.o_coeffs_a), 32'h00);
    chk("rst_b", 32'(if8.o_coeffs_b), 32'h00);
    chk("rst_sel", 32'(if8.o_sel), 32'h0);
    chk("rst_ready", 32'(if8.o_update_ready), 32'h1);
    chk("rst_busy", 32'(if8.o_busy), 32'h0);
    chk("rst_done", 32'(if8.o_switch_done), 32'h0);
    step(1);

    // First update 0xA5 lands in bank B.
    if8.i_update_valid = 1'b1; if8.i_coeffs = 8'hA5;
    step(1);
    if8.i_update_valid = 1'b0;
    chk("a5_b", 32'(if8.o_coeffs_b), 32'hA5);
    chk("a5_a", 32'(if8.o_coeffs_a), 32'h00);
    chk("a5_ready_low", 32'(if8.o_update_ready), 32'h0);
    step(7);
    chk("a5_sel_n7", 32'(if8.o_sel), 32'h0);
    step(1);
    chk("a5_sel_n8", 32'(if8.o_sel), 32'h1);
    step(7);
    chk("a5_ready_n15", 32'(if8.o_update_ready), 32'h0);
    chk("a5_done_n15", 32'(if8.o_switch_done), 32'h0);
    step(1);
    chk("a5_ready_n16", 32'(if8.o_update_ready), 32'h1);
    chk("a5_done_n16", 32'(if8.o_switch_done), 32'h1);

    // Second update 0x3C accepted in the same cycle as the done pulse; goes to bank A.
    if8.i_update_valid = 1'b1; if8.i_coeffs = 8'h3C;
    step(1);
    if8.i_update_valid = 1'b0;
    chk("3c_a", 32'(if8.o_coeffs_a), 32'h3C);
    chk("3c_b", 32'(if8.o_coeffs_b), 32'hA5);
    chk("3c_done_clr", 32'(if8.o_switch_done), 32'h0);
    step(8);
    chk("3c_sel", 32'(if8.o_sel), 32'h0);
    step(8);
    chk("3c_done", 32'(if8.o_switch_done), 32'h1);

    // Valid held high: only accepted when ready, nothing captured while busy.
    if8.i_update_valid = 1'b1; if8.i_coeffs = 8'h11;
    step(1);
    chk("hold_b11", 32'(if8.o_coeffs_b), 32'h11);
    if8.i_coeffs = 8'h22;
    step(16);
    chk("hold_a_busy", 32'(if8.o_coeffs_a), 32'h3C);
    chk("hold_b_busy", 32'(if8.o_coeffs_b), 32'h11);
    step(1);
    if8.i_update_valid = 1'b0;
    chk("hold_a22", 32'(if8.o_coeffs_a), 32'h22);
    step(7);
    chk("hold_sel_before", 32'(if8.o_sel), 32'h1);
    step(1);
    chk("hold_sel_after", 32'(if8.o_sel), 32'h0);
    step(9);

    // Reset during SETTLE_DATA aborts the pending toggle.
    if8.i_update_valid = 1'b1; if8.i_coeffs = 8'h55;
    step(1);
    if8.i_update_valid = 1'b0;
    chk("rmid_b55", 32'(if8.o_coeffs_b), 32'h55);
    step(2);
    rst8 = 1'b1;
    if8.i_update_valid = 1'b1;
    step(1);
    rst8 = 1'b0;
    if8.i_update_valid = 1'b0;
    chk("rmid_b0", 32'(if8.o_coeffs_b), 32'h00);
    chk("rmid_a0", 32'(if8.o_coeffs_a), 32'h00);
    chk("rmid_ready", 32'(if8.o_update_ready), 32'h1);
    step(6);
    chk("rmid_sel", 32'(if8.o_sel), 32'h0);
    step(12);

    // SETTLE_CYCLES=1 instance.
    if1.i_update_valid = 1'b1; if1.i_coeffs = 8'h7F;
    step(1);
    if1.i_update_valid = 1'b0;
    chk("s1_b", 32'(if1.o_coeffs_b), 32'h7F);
    chk("s1_sel0", 32'(if1.o_sel), 32'h0);
    step(1);
    chk("s1_sel1", 32'(if1.o_sel), 32'h1);
    chk("s1_ready_busy", 32'(if1.o_update_ready), 32'h0);
    step(1);
    chk("s1_ready", 32'(if1.o_update_ready), 32'h1);
    chk("s1_done", 32'(if1.o_switch_done), 32'h1);
    step(1);
    chk("s1_done_clr", 32'(if1.o_switch_done), 32'h0);
    if1.i_update_valid = 1'b1; if1.i_coeffs = 8'h81;
    step(1);
    if1.i_update_valid = 1'b0;
    chk("s1_a", 32'(if1.o_coeffs_a), 32'h81);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
